// File: rtl/capture_pkg.sv
// Shared types and default sizing for the silencer stream capture block.
package capture_pkg;

  localparam int unsigned DefaultDepth = 249;
  localparam int unsigned IntensityW   = 16;
  localparam int unsigned PhaseW       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone,
    StDrain
  } capture_state_t;

  typedef struct packed {
    logic [IntensityW-1:0] intensity;
    logic [PhaseW-1:0]     phase;
  } drive_t;

endpackage

// File: rtl/capture_bank_ram.sv
// Two banks of Depth drive words: one write port, one registered read port.
module capture_bank_ram
  import capture_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic            wbank_i,
  input  logic [IdxW-1:0] widx_i,
  input  drive_t          wdata_i,
  input  logic            rbank_i,
  input  logic [IdxW-1:0] ridx_i,
  output drive_t          rdata_o
);

  localparam int unsigned AddrW = $clog2(2 * Depth);

  drive_t             mem [2*Depth];
  drive_t             rdata_q;
  logic   [AddrW-1:0] waddr;
  logic   [AddrW-1:0] raddr;

  assign waddr   = wbank_i ? AddrW'(Depth) + AddrW'(widx_i) : AddrW'(widx_i);
  assign raddr   = rbank_i ? AddrW'(Depth) + AddrW'(ridx_i) : AddrW'(ridx_i);
  assign rdata_o = rdata_q;

  // Write-first so a read on the swap edge of the last beat sees the new word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr] <= wdata_i;
    end
    if (we_i && (waddr == raddr)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

endmodule

// File: rtl/silencer_stream_capture.sv
// Double-buffered capture of one silencer burst per frame, swapped atomically on completion.
// Optional frame checksum output enabled by SILENCER_STREAM_CAPTURE_CHECKSUM_EN.
module silencer_stream_capture
  import capture_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  din_valid_i,
  input  logic [IntensityW-1:0] intensity_i,
  input  logic [PhaseW-1:0]     phase_i,
  input  logic [IdxW-1:0]       rd_idx_i,
  output logic [IntensityW-1:0] intensity_o,
  output logic [PhaseW-1:0]     phase_o,
  output logic                  frame_valid_o,
  output logic                  frame_update_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  err_short_o,
  input  logic                  err_clr_i,
`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
  output logic [IntensityW+PhaseW-1:0] frame_xor_o,
`endif
  output logic                  err_long_o
);

  capture_state_t  state_q;
  logic [IdxW-1:0] wr_idx_q;
  logic            bank_q, bank_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_update_q, err_short_q, err_long_q, rd_ok_q;
  logic [15:0]     frame_cnt_q;
  logic            we, swap, rd_in_range;
  logic [IdxW-1:0] widx, ridx;
  drive_t          din, rdata;

  always_comb begin
    din         = '{intensity: intensity_i, phase: phase_i};
    we          = din_valid_i && ((state_q == StIdle) || (state_q == StFill));
    widx        = (state_q == StFill) ? wr_idx_q : '0;
    swap        = (state_q == StFill) && din_valid_i && (wr_idx_q == IdxW'(Depth - 1));
    bank_d      = bank_q ^ swap;
    frame_valid_d = frame_valid_q | swap;
    rd_in_range = 32'(rd_idx_i) < Depth;
    ridx        = rd_in_range ? rd_idx_i : '0;
  end

  // Writes go to the shadow bank; reads follow the bank that is active after this edge.
  capture_bank_ram #(
    .Depth (Depth)
  ) u_bank_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .wbank_i (~bank_q),
    .widx_i  (widx),
    .wdata_i (din),
    .rbank_i (bank_d),
    .ridx_i  (ridx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      wr_idx_q       <= '0;
      bank_q         <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_update_q <= 1'b0;
      frame_cnt_q    <= '0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      rd_ok_q        <= 1'b0;
    end else begin
      bank_q         <= bank_d;
      frame_valid_q  <= frame_valid_d;
      frame_update_q <= swap;
      rd_ok_q        <= frame_valid_d && rd_in_range;
      if (swap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // Clear first; a same-cycle error below overrides it.
      if (err_clr_i) begin
        err_short_q <= 1'b0;
        err_long_q  <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (din_valid_i) begin
            wr_idx_q <= IdxW'(1);
            state_q  <= StFill;
          end
        end
        StFill: begin
          if (!din_valid_i) begin
            err_short_q <= 1'b1;
            wr_idx_q    <= '0;
            state_q     <= StIdle;
          end else if (swap) begin
            wr_idx_q <= '0;
            state_q  <= StDone;
          end else begin
            wr_idx_q <= wr_idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (din_valid_i) begin
            err_long_q <= 1'b1;
            state_q    <= StDrain;
          end else begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (!din_valid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
  logic [IntensityW+PhaseW-1:0] xor_acc_q, frame_xor_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xor_acc_q   <= '0;
      frame_xor_q <= '0;
    end else begin
      if (we) begin
        xor_acc_q <= ((state_q == StIdle) ? '0 : xor_acc_q) ^ din;
      end
      if (swap) begin
        frame_xor_q <= xor_acc_q ^ din;
      end
    end
  end

  assign frame_xor_o = frame_xor_q;
`endif

  assign intensity_o    = rd_ok_q ? rdata.intensity : '0;
  assign phase_o        = rd_ok_q ? rdata.phase : '0;
  assign frame_valid_o  = frame_valid_q;
  assign frame_update_o = frame_update_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign err_short_o    = err_short_q;
  assign err_long_o     = err_long_q;

endmodule

// File: tb/tb_silencer_stream_capture.sv
// Directed bench for silencer_stream_capture; checksum checks follow
// SILENCER_STREAM_CAPTURE_CHECKSUM_EN.
module tb_silencer_stream_capture;
  import capture_pkg::*;

  localparam int unsigned Depth = DefaultDepth;
  localparam int unsigned IdxW  = $clog2(Depth);

  logic                  clk;
  logic                  rst_n;
  logic                  din_valid;
  logic [IntensityW-1:0] intensity_in;
  logic [PhaseW-1:0]     phase_in;
  logic [IdxW-1:0]       rd_idx;
  logic [IntensityW-1:0] intensity_out;
  logic [PhaseW-1:0]     phase_out;
  logic                  frame_valid;
  logic                  frame_update;
  logic [15:0]           frame_cnt;
  logic                  err_short;
  logic                  err_long;
  logic                  err_clr;
`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
  logic [IntensityW+PhaseW-1:0] frame_xor;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  silencer_stream_capture #(
    .Depth (Depth)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .din_valid_i    (din_valid),
    .intensity_i    (intensity_in),
    .phase_i        (phase_in),
    .rd_idx_i       (rd_idx),
    .intensity_o    (intensity_out),
    .phase_o        (phase_out),
    .frame_valid_o  (frame_valid),
    .frame_update_o (frame_update),
    .frame_cnt_o    (frame_cnt),
    .err_short_o    (err_short),
    .err_clr_i      (err_clr),
`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
    .frame_xor_o    (frame_xor),
`endif
    .err_long_o     (err_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Beat patterns: 0 ramp*7, 1 constant AAAA/55, 2 constant phase prm, 3 scrambled.
  function automatic logic [15:0] exp_i(input int kind, input int prm, input int i);
    case (kind)
      0:       return 16'(i * 7);
      1:       return 16'hAAAA;
      2:       return 16'(i + prm * 256);
      default: return 16'(i * 3 + 1) ^ 16'h1234;
    endcase
  endfunction

  function automatic logic [7:0] exp_p(input int kind, input int prm, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'h55;
      2:       return 8'(prm);
      default: return ~8'(i + prm);
    endcase
  endfunction

  function automatic logic [23:0] xor_model(input int kind, input int prm);
    logic [23:0] acc = '0;
    for (int i = 0; i < int'(Depth); i++) acc ^= {exp_i(kind, prm, i), exp_p(kind, prm, i)};
    return acc;
  endfunction

  task automatic send_beats(input int n, input int kind, input int prm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid    = 1'b1;
      intensity_in = exp_i(kind, prm, i);
      phase_in     = exp_p(kind, prm, i);
    end
    @(negedge clk);
    din_valid    = 1'b0;
    intensity_in = '0;
    phase_in     = '0;
  endtask

  task automatic read_frame(input string tag, input int kind, input int prm, input bit zero);
    @(negedge clk);
    for (int idx = 0; idx < int'(Depth); idx++) begin
      rd_idx = IdxW'(idx);
      @(negedge clk);
      check($sformatf("%s_int_%0d", tag, idx), 32'(intensity_out),
            zero ? 32'd0 : 32'(exp_i(kind, prm, idx)));
      check($sformatf("%s_ph_%0d", tag, idx), 32'(phase_out),
            zero ? 32'd0 : 32'(exp_p(kind, prm, idx)));
    end
  endtask

  task automatic check_xor(input string tag, input int kind, input int prm);
`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
    check(tag, 32'(frame_xor), 32'(xor_model(kind, prm)));
`endif
  endtask

  initial begin
    int mix;
    rst_n = 1'b0; din_valid = 1'b0; intensity_in = '0; phase_in = '0;
    rd_idx = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and empty reads
    @(negedge clk);
    check("rst_fvalid", 32'(frame_valid), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_upd", 32'(frame_update), 0);
    check("rst_errs", 32'({err_short, err_long}), 0);
`ifdef SILENCER_STREAM_CAPTURE_CHECKSUM_EN
    check("rst_xor", 32'(frame_xor), 0);
`endif
    read_frame("t1", 0, 0, 1'b1);

    // First frame
    send_beats(Depth, 0, 0);
    check("t2_upd", 32'(frame_update), 1);
    check("t2_fvalid", 32'(frame_valid), 1);
    check("t2_cnt", 32'(frame_cnt), 1);
    @(negedge clk);
    check("t2_upd_once", 32'(frame_update), 0);
    read_frame("t2", 0, 0, 1'b0);
    rd_idx = IdxW'(Depth);
    @(negedge clk);
    check("t2_oor_249", 32'({intensity_out, phase_out}), 0);
    rd_idx = '1;
    @(negedge clk);
    check("t2_oor_255", 32'({intensity_out, phase_out}), 0);
    check_xor("t2_xor", 0, 0);

    // Frame 2 then a short burst
    send_beats(Depth, 3, 0);
    check("f2_cnt", 32'(frame_cnt), 2);
    send_beats(100, 1, 0);
    @(negedge clk);
    check("t3_short", 32'(err_short), 1);
    check("t3_long", 32'(err_long), 0);
    check("t3_cnt", 32'(frame_cnt), 2);
    check("t3_upd", 32'(frame_update), 0);
    read_frame("t3", 3, 0, 1'b0);
    check_xor("t3_xor", 3, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_clr", 32'(err_short), 0);

    // Error and clear on the same edge: error wins
    err_clr = 1'b1;
    send_beats(10, 1, 0);
    @(negedge clk);
    check("t3_err_wins", 32'(err_short), 1);
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_clr2", 32'(err_short), 0);

    // Long burst: swap at beat 249, excess dropped
    send_beats(260, 3, 1);
    @(negedge clk);
    check("t4_long", 32'(err_long), 1);
    check("t4_short", 32'(err_short), 0);
    check("t4_cnt", 32'(frame_cnt), 3);
    read_frame("t4", 3, 1, 1'b0);
    check_xor("t4_xor", 3, 1);
    send_beats(Depth, 0, 0);
    check("t4b_upd", 32'(frame_update), 1);
    check("t4b_cnt", 32'(frame_cnt), 4);
    check("t4b_long_sticky", 32'(err_long), 1);
    read_frame("t4b", 0, 0, 1'b0);
    check_xor("t4b_xor", 0, 0);

    // Held read index across two frames
    rd_idx = IdxW'(5);
    send_beats(Depth, 2, 10);
    check("t5_a_ph", 32'(phase_out), 10);
    check("t5_a_int", 32'(intensity_out), 32'(5 + 10 * 256));
    mix = 0;
    for (int i = 0; i < int'(Depth); i++) begin
      @(negedge clk);
      if (phase_out !== 8'd10 || intensity_out !== 16'(5 + 10 * 256)) mix++;
      din_valid    = 1'b1;
      intensity_in = exp_i(2, 20, i);
      phase_in     = exp_p(2, 20, i);
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("t5_no_early_change", 32'(mix), 0);
    check("t5_b_ph", 32'(phase_out), 20);
    check("t5_b_int", 32'(intensity_out), 32'(5 + 20 * 256));
    check("t5_b_upd", 32'(frame_update), 1);

    // Reset in the middle of a burst
    for (int i = 0; i <= 120; i++) begin
      @(negedge clk);
      din_valid    = 1'b1;
      intensity_in = exp_i(1, 0, i);
      phase_in     = exp_p(1, 0, i);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data", 32'({intensity_out, phase_out}), 0);
    check("t6_rst_flags", 32'({frame_valid, frame_update, err_short, err_long}), 0);
    check("t6_rst_cnt", 32'(frame_cnt), 0);
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beats(Depth, 3, 5);
    check("t6_cnt", 32'(frame_cnt), 1);
    check("t6_upd", 32'(frame_update), 1);
    read_frame("t6", 3, 5, 1'b0);
    check_xor("t6_xor", 3, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
